// File: rtl/sdram_burst_arbiter.sv
// Burst scheduler between NUM_WR write FIFOs, one display read FIFO and a
// full-page SDRAM controller: round-robin writers, critical-read preemption.
module sdram_burst_arbiter #(
  parameter int NUM_WR          = 2,
  parameter int DATA_W          = 16,
  parameter int CNT_W           = 10,
  parameter int ADDR_W          = 12,
  parameter int PAGES_PER_FRAME = 600,
  parameter int BURST_LEN       = 512,
  parameter int WR_THRESH       = 512,
  parameter int RD_LOW_WATER    = 250,
  parameter int RD_CRIT         = 64,
  localparam int SEL_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1,
  localparam int GNT_W = $clog2(NUM_WR) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_WR*CNT_W-1:0]  wr_count,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [NUM_WR-1:0]        wr_pop,
  input  logic [CNT_W-1:0]         rd_count,
  input  logic [SEL_W-1:0]         rd_sel,
  output logic                     rd_push,
  input  logic                     ready,
  output logic                     rw,
  output logic                     rw_en,
  output logic [ADDR_W-1:0]        f_addr,
  output logic [DATA_W-1:0]        f2s_data,
  input  logic                     f2s_data_valid,
  input  logic                     s2f_data_valid,
  output logic [GNT_W-1:0]         grant,
  output logic [NUM_WR:0]          frame_done,
  output logic                     len_err
);
  localparam int PTR_W = (PAGES_PER_FRAME > 1) ? $clog2(PAGES_PER_FRAME) : 1;
  localparam int WC_W  = $clog2(BURST_LEN + 1);
  localparam logic [GNT_W-1:0]  RD_OWN    = GNT_W'(NUM_WR);
  localparam logic [CNT_W-1:0]  L_WR_TH   = CNT_W'(WR_THRESH);
  localparam logic [CNT_W-1:0]  L_RD_LOW  = CNT_W'(RD_LOW_WATER);
  localparam logic [CNT_W-1:0]  L_RD_CRIT = CNT_W'(RD_CRIT);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(PAGES_PER_FRAME - 1);
  localparam logic [WC_W-1:0]   WC_FULL   = WC_W'(BURST_LEN);

  if (NUM_WR < 1 || NUM_WR > 6) begin : g_nwr_chk
    $error("sdram_burst_arbiter: NUM_WR must be 1..6");
  end
  if (NUM_WR * PAGES_PER_FRAME > 2 ** ADDR_W) begin : g_addr_chk
    $error("sdram_burst_arbiter: frame regions exceed page address space");
  end

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT_LO, S_RUN} state_t;

  state_t             r_state;
  logic [GNT_W-1:0]   r_grant, r_last_wr;
  logic               r_rw, r_rw_en, r_len_err, r_rd_init;
  logic [ADDR_W-1:0]  r_f_addr;
  logic [NUM_WR:0]    r_frame_done;
  logic [PTR_W-1:0]   r_wp [NUM_WR];
  logic [PTR_W-1:0]   r_rp;
  logic [SEL_W-1:0]   r_rd_region;
  logic [WC_W-1:0]    r_wcnt;

  logic               w_wr_hit, w_req, w_xfer;
  logic [GNT_W-1:0]   w_wr_sel, w_sel, w_region, w_gidx;
  int unsigned        w_idx;
  logic [PTR_W-1:0]   w_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0]  w_addr;
  logic [SEL_W-1:0]   w_rd_sel_ok;
  logic [WC_W-1:0]    w_wcnt_nxt;

  // Round-robin scan starts one past the last served writer.
  always_comb begin
    w_wr_hit = 1'b0;
    w_wr_sel = '0;
    w_idx    = 0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      w_idx = 32'(r_last_wr) + 32'd1 + i;
      if (w_idx >= NUM_WR) w_idx = w_idx - NUM_WR;
      if (!w_wr_hit && (wr_count[w_idx*CNT_W +: CNT_W] > L_WR_TH)) begin
        w_wr_hit = 1'b1;
        w_wr_sel = GNT_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_req = 1'b1;
    w_sel = RD_OWN;
    if (rd_count < L_RD_CRIT)      w_sel = RD_OWN;
    else if (w_wr_hit)             w_sel = w_wr_sel;
    else if (rd_count < L_RD_LOW)  w_sel = RD_OWN;
    else                           w_req = 1'b0;
  end

  always_comb begin
    if (w_sel == RD_OWN) begin
      w_ptr    = r_rp;
      w_region = GNT_W'(r_rd_region);
    end else begin
      w_ptr    = r_wp[w_sel];
      w_region = w_sel;
    end
    w_ptr_nxt   = (w_ptr == PTR_LAST) ? '0 : w_ptr + 1'b1;
    w_addr      = ADDR_W'(w_region) * ADDR_W'(PAGES_PER_FRAME) + ADDR_W'(w_ptr);
    w_rd_sel_ok = (32'(rd_sel) < NUM_WR) ? rd_sel : '0;
  end

  always_comb begin
    w_gidx   = (r_grant < RD_OWN) ? r_grant : '0;
    f2s_data = wr_data[w_gidx*DATA_W +: DATA_W];
    w_xfer   = (r_state == S_WAIT_LO) || (r_state == S_RUN);
    wr_pop   = '0;
    for (int unsigned k = 0; k < NUM_WR; k++)
      wr_pop[k] = f2s_data_valid && w_xfer && (r_grant == GNT_W'(k));
    rd_push    = s2f_data_valid && (r_grant == RD_OWN);
    w_wcnt_nxt = r_wcnt + WC_W'((|wr_pop) || rd_push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_wr    <= GNT_W'(NUM_WR - 1);
      r_rw         <= 1'b0;
      r_rw_en      <= 1'b0;
      r_len_err    <= 1'b0;
      r_rd_init    <= 1'b1;
      r_f_addr     <= '0;
      r_frame_done <= '0;
      r_rp         <= '0;
      r_rd_region  <= '0;
      r_wcnt       <= '0;
      for (int unsigned k = 0; k < NUM_WR; k++) r_wp[k] <= '0;
    end else begin
      r_rw_en      <= 1'b0;
      r_frame_done <= '0;
      r_wcnt       <= w_wcnt_nxt;
      if (r_rd_init) begin
        r_rd_init   <= 1'b0;
        r_rd_region <= w_rd_sel_ok;
      end
      case (r_state)
        S_IDLE: if (enable) r_state <= S_ARB;
        S_ARB: begin
          if (ready) begin
            if (!enable) begin
              r_state <= S_IDLE;
            end else if (w_req) begin
              r_state  <= S_ISSUE;
              r_rw_en  <= 1'b1;
              r_rw     <= (w_sel == RD_OWN);
              r_f_addr <= w_addr;
              r_grant  <= w_sel;
              if (w_ptr == PTR_LAST) r_frame_done[w_sel] <= 1'b1;
              // Display region only switches when the read pointer wraps.
              if (w_sel == RD_OWN) begin
                r_rp <= w_ptr_nxt;
                if (w_ptr == PTR_LAST) r_rd_region <= w_rd_sel_ok;
              end else begin
                r_wp[w_sel] <= w_ptr_nxt;
                r_last_wr   <= w_sel;
              end
            end
          end
        end
        S_ISSUE:   r_state <= S_WAIT_LO;
        S_WAIT_LO: if (!ready) r_state <= S_RUN;
        S_RUN: begin
          if (ready) begin
            r_state <= S_ARB;
            if (w_wcnt_nxt != WC_FULL) r_len_err <= 1'b1;
            r_wcnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rw         = r_rw;
  assign rw_en      = r_rw_en;
  assign f_addr     = r_f_addr;
  assign grant      = r_grant;
  assign frame_done = r_frame_done;
  assign len_err    = r_len_err;
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed + randomized bench for sdram_burst_arbiter with a behavioural
// controller and a page-pointer / priority reference model.
module tb_sdram_burst_arbiter;
  localparam int NW = 2, DW = 16, CW = 10, AW = 12, PPF = 600, BL = 512;

  logic              clk = 1'b0;
  logic              rst_n, enable, ready, rw, rw_en, rd_push, len_err;
  logic              f2s_data_valid, s2f_data_valid;
  logic [NW*CW-1:0]  wr_count;
  logic [NW*DW-1:0]  wr_data;
  logic [NW-1:0]     wr_pop;
  logic [CW-1:0]     rd_count;
  logic [0:0]        rd_sel;
  logic [AW-1:0]     f_addr;
  logic [DW-1:0]     f2s_data;
  logic [1:0]        grant;
  logic [NW:0]       frame_done;

  sdram_burst_arbiter #(
    .NUM_WR(NW), .DATA_W(DW), .CNT_W(CW), .ADDR_W(AW), .PAGES_PER_FRAME(PPF),
    .BURST_LEN(BL), .WR_THRESH(512), .RD_LOW_WATER(250), .RD_CRIT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_count(wr_count),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_count(rd_count), .rd_sel(rd_sel),
    .rd_push(rd_push), .ready(ready), .rw(rw), .rw_en(rw_en), .f_addr(f_addr),
    .f2s_data(f2s_data), .f2s_data_valid(f2s_data_valid),
    .s2f_data_valid(s2f_data_valid), .grant(grant), .frame_done(frame_done),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int wc[NW];
  int rc;
  int m_wp[NW];
  int m_rp, m_last, m_reg;
  bit m_lerr;
  bit seen;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int w0, input int w1, input int r);
    wc[0] = w0; wc[1] = w1; rc = r;
    wr_count = {CW'(w1), CW'(w0)};
    rd_count = CW'(r);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NW; k++) m_wp[k] = 0;
    m_rp = 0; m_last = NW - 1; m_reg = int'(rd_sel); m_lerr = 0;
  endtask

  // Owner chosen from the priority rules: critical read, RR writers, low-water read.
  function automatic int predict();
    if (rc < 64) return NW;
    for (int i = 1; i <= NW; i++) begin
      int k = (m_last + i) % NW;
      if (wc[k] > 512) return k;
    end
    if (rc < 250) return NW;
    return -1;
  endfunction

  task automatic burst(input int n);
    int own, ptr, base, cnt;
    bit hit;
    own = predict();
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (rw_en === 1'b1) hit = 1;
    end
    check("rw_en_seen", 32'(hit), 1);
    if (!hit || own < 0) return;
    ptr  = (own == NW) ? m_rp : m_wp[own];
    base = (own == NW) ? m_reg : own;
    check("grant", 32'(grant), own);
    check("rw", 32'(rw), (own == NW) ? 1 : 0);
    check("f_addr", 32'(f_addr), base * PPF + ptr);
    check("frame_done", 32'(frame_done), (ptr == PPF - 1) ? (1 << own) : 0);
    if (own == NW) begin
      m_rp = (m_rp + 1) % PPF;
      if (m_rp == 0) m_reg = int'(rd_sel);
    end else begin
      m_wp[own] = (m_wp[own] + 1) % PPF;
      m_last = own;
    end
    ready = 1'b0;
    @(negedge clk);
    check("rw_en_one_cycle", 32'(rw_en), 0);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      wr_data = $urandom;
      if (own == NW) s2f_data_valid = 1'b1; else f2s_data_valid = 1'b1;
      #1;
      if (own < NW) begin
        if (wr_pop === NW'(1 << own) && rd_push === 1'b0) cnt++;
        if (i == 0) check("f2s_data", 32'(f2s_data), 32'(wr_data[own*DW +: DW]));
      end else if (rd_push === 1'b1 && wr_pop === '0) begin
        cnt++;
      end
      @(negedge clk);
    end
    f2s_data_valid = 1'b0; s2f_data_valid = 1'b0; ready = 1'b1;
    check("words", 32'(cnt), n);
    if (n != BL) m_lerr = 1;
    @(negedge clk);
    check("len_err", 32'(len_err), 32'(m_lerr));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; ready = 1'b1; rd_sel = 1'b0;
    f2s_data_valid = 1'b0; s2f_data_valid = 1'b0;
    wr_data = 32'hABCD_1234;
    set_in(0, 0, 500);
    repeat (3) @(negedge clk);
    check("rst_rw_en", 32'(rw_en), 0);
    check("rst_rw", 32'(rw), 0);
    check("rst_f_addr", 32'(f_addr), 0);
    check("rst_wr_pop", 32'(wr_pop), 0);
    check("rst_rd_push", 32'(rd_push), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_len_err", 32'(len_err), 0);
    check("rst_f2s_data", 32'(f2s_data), 32'h1234);
    rst_n = 1'b1; model_reset(); enable = 1'b1;

    // Single writer full burst, then a short burst making len_err sticky.
    set_in(513, 0, 500);
    burst(BL);
    burst(BL - 1);
    burst(BL);

    // Asynchronous reset in the middle of a write burst.
    set_in(600, 0, 500);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (rw_en === 1'b1) seen = 1;
    end
    check("mid_rst_issue", 32'(seen), 1);
    ready = 1'b0;
    @(negedge clk);
    f2s_data_valid = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rw_en", 32'(rw_en), 0);
    check("mid_rst_f_addr", 32'(f_addr), 0);
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_wr_pop", 32'(wr_pop), 0);
    check("mid_rst_len_err", 32'(len_err), 0);
    check("mid_rst_frame_done", 32'(frame_done), 0);
    f2s_data_valid = 1'b0; ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; model_reset();

    // Both writers saturated: alternating grants 0,1,0,1.
    set_in(600, 600, 500);
    for (int i = 0; i < 4; i++) burst(4);

    // Critical read preempts a writer; moderate read does not.
    set_in(600, 0, 40);
    burst(4);
    set_in(600, 0, 200);
    burst(4);

    // enable low holds off new bursts.
    enable = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rw_en === 1'b1) seen = 1;
    end
    check("enable_gate", 32'(seen), 0);
    enable = 1'b1;

    // Writer 0 page pointer wrap.
    set_in(600, 0, 500);
    for (int i = 0; i < PPF + 1; i++) burst(1);

    // Reader: switch region request mid-frame; takes effect only at wrap.
    set_in(0, 0, 40);
    for (int i = 0; i < PPF && m_rp != 300; i++) burst(1);
    rd_sel = 1'b1;
    for (int i = 0; i < PPF - 300 + 2; i++) burst(1);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      set_in($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
      if (predict() < 0) set_in(600, wc[1], rc);
      rd_sel = 1'($urandom_range(0, 1));
      burst($urandom_range(1, 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
